uart_cmd_ctrl: RTL
==================

# uart_cmd_ctrl

Frame-level command controller between the `uart_rx` byte receiver and the command consumers. It hunts for a sync byte and assembles a 4-byte frame: sync, opcode, argument, checksum. It validates the frame, then presents a 3-bit command plus 8-bit argument downstream on a valid/ready handshake. Malformed, stale or overrun traffic is discarded and flagged. The block replaces the free-running 4-byte shift buffer with a sequenced parser.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYC`, default 100000: maximum idle cycles between bytes inside a frame. Legal range 2 to 2^24.

Ports:
- `clk`, input, 1 bit: single clock.
- `rst_n`, input, 1 bit: reset, synchronous and active-low.
- `iRxDv`, input, 1 bit: one-cycle byte strobe from `uart_rx` `o_Rx_DV`.
- `iRxByte`, input, 8 bits: received byte, valid when `iRxDv` is high.
- `oCmdValid`, output, 1 bit: command available.
- `oCmd`, output, 3 bits: command code, taken from opcode[2:0].
- `oCmdArg`, output, 8 bits: command argument.
- `iCmdReady`, input, 1 bit: consumer accepts the command.
- `oBusy`, output, 1 bit: high in any state other than IDLE.
- `oErrPulse`, output, 1 bit: one-cycle pulse on any frame error.
- `oErrCode`, output, 2 bits: cause of the last error. 0 = checksum, 1 = bad opcode, 2 = timeout, 3 = overrun. Holds its value until the next error.
- `oErrCnt`, output, 8 bits: total error count, saturating at 255.

## Operation
- Frame layout: SYNC, OPC, ARG, CHK. The frame is valid when CHK == OPC ^ ARG and OPC[7:3] == 0.
- State machine states: IDLE, OPC, ARG, CHK, HOLD.
- IDLE:
  - A byte equal to `SYNC_BYTE` moves the state to OPC.
  - Any other byte is silently discarded. It is not counted as an error.
- OPC:
  - Latch the byte and go to ARG.
  - No resync: a byte equal to `SYNC_BYTE` in this position is treated as an opcode.
- ARG: latch the byte and go to CHK.
- CHK:
  - On a checksum mismatch, raise error code 0 and go to IDLE.
  - Otherwise, on OPC[7:3] != 0, raise error code 1 and go to IDLE.
  - Otherwise load `oCmd`/`oCmdArg`, assert `oCmdValid`, and go to HOLD.
  - When both errors are present, checksum wins.
- HOLD:
  - `oCmdValid`, `oCmd` and `oCmdArg` stay stable until a cycle where `oCmdValid` and `iCmdReady` are both high. The next state is then IDLE.
  - Any `iRxDv` while in HOLD, including on the handshake cycle, drops the byte and raises error code 3.
- Error counter: increments on every `oErrPulse` and saturates at 255. It is cleared only by reset.
- Reset mid-frame: the partial frame is discarded and all state is lost.

## Timing
- Reset values: `oCmdValid` = 0, `oCmd` = 0, `oCmdArg` = 0, `oBusy` = 0, `oErrPulse` = 0, `oErrCode` = 0, `oErrCnt` = 0. State is IDLE.
- Each byte is consumed on the `clk` edge where `iRxDv` = 1.
- If the CHK byte is strobed at cycle N, `oCmdValid` is high from N+1.
- If the handshake completes at cycle M, `oCmdValid` is 0 at M+1.
- Ready may be high before valid rises; the handshake then completes on the first valid cycle.
- `oErrPulse`, `oErrCode` and the `oErrCnt` increment all appear at N+1 for an offending byte at N.
- Minimum frame-to-command latency is 4 byte strobes plus 1 cycle.

## Configuration
- Macro `UART_CMD_TIMEOUT_EN`.
- Defined:
  - An inter-byte counter clears on every `iRxDv` in OPC, ARG or CHK and increments on other cycles in those states.
  - When the counter reaches `TIMEOUT_CYC`-1, raise error code 2 and go to IDLE.
  - If a byte strobe arrives on the same cycle the limit is reached, the byte wins: it is processed and no timeout is raised.
  - The counter is held at 0 in IDLE and HOLD.
- Undefined:
  - No counter is built and a partial frame waits indefinitely.
  - Error code 2 is never produced.
  - `TIMEOUT_CYC` is ignored.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum `cmd_state_t`;
  - the error code enum `cmd_err_t`;
  - the default sync constant;
  - the opcode width constant (3).
- Sub-module `uart_cmd_timer` holds the inter-byte counter with clear, enable and expire. It is instantiated only under `UART_CMD_TIMEOUT_EN`.
- `uart_rx` is instantiated by the parent, not inside this block.

## Test plan
- Bytes A5, 05, 3C, 39 with ready high → one `oCmdValid` cycle with `oCmd`=5, `oCmdArg`=8'h3C, and no error.
- Bytes 11, 22, A5, 02, 10, 12 → leading garbage ignored, command 2 with arg 8'h10, `oErrCnt` stays 0.
- Bytes A5, 01, 02, 00 → `oErrPulse`, `oErrCode`=0, `oErrCnt`=1. Then the valid frame A5, 01, 02, 03 is accepted.
- Bytes A5, 09, 00, 09 → `oErrCode`=1 and no command.
- A valid frame with ready held low for 20 cycles, plus one byte strobed during HOLD → `oCmd` stable throughout, `oErrCode`=3, and the command delivered when ready rises.
- With `UART_CMD_TIMEOUT_EN` defined and `TIMEOUT_CYC`=16: send A5, 03, then idle → `oErrCode`=2 exactly 16 cycles after the 03 strobe. Also drive 260 bad frames → `oErrCnt` saturates at 255.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_ARG  = 3'd2,
        ST_CHK  = 3'd3,
        ST_HOLD = 3'd4
    } cmd_state_t;

    typedef enum logic [1:0] {
        ERR_CHKSUM  = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } cmd_err_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         OPC_W        = 3;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte idle counter: held at zero when disabled or cleared, flags expiry
// on the cycle the count sits at TIMEOUT_CYC-1 with no clearing strobe.
module uart_cmd_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [23:0] LIMIT = 24'(TIMEOUT_CYC - 1);

    logic [23:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr || !en)
            cnt <= '0;
        else
            cnt <= cnt + 24'd1;
    end

    // A strobe on the limit cycle takes priority, so expiry is masked by clr.
    assign expire = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Sequenced SYNC/OPC/ARG/CHK frame parser with valid/ready command output.
// Optional inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iRxDv,
    input  logic [7:0]       iRxByte,
    output logic             oCmdValid,
    output logic [OPC_W-1:0] oCmd,
    output logic [7:0]       oCmdArg,
    input  logic             iCmdReady,
    output logic             oBusy,
    output logic             oErrPulse,
    output logic [1:0]       oErrCode,
    output logic [7:0]       oErrCnt
);

    cmd_state_t state;
    logic [7:0] opc_q;
    logic [7:0] arg_q;
    logic       tmo_expire;

`ifdef UART_CMD_TIMEOUT_EN
    logic tmo_en;
    assign tmo_en = (state == ST_OPC) || (state == ST_ARG) || (state == ST_CHK);

    uart_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (iRxDv),
        .en     (tmo_en),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign oBusy = (state != ST_IDLE);

    // Frame payload bytes carry no reset; they are only read once fully captured.
    always_ff @(posedge clk) begin
        if (iRxDv && state == ST_OPC) opc_q <= iRxByte;
        if (iRxDv && state == ST_ARG) arg_q <= iRxByte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            oCmdValid <= 1'b0;
            oCmd      <= '0;
            oCmdArg   <= '0;
            oErrPulse <= 1'b0;
            oErrCode  <= ERR_CHKSUM;
            oErrCnt   <= '0;
        end else begin
            oErrPulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iRxDv && iRxByte == SYNC_BYTE)
                        state <= ST_OPC;
                end
                ST_OPC, ST_ARG: begin
                    if (iRxDv) begin
                        state <= (state == ST_OPC) ? ST_ARG : ST_CHK;
                    end else if (tmo_expire) begin
                        oErrPulse <= 1'b1;
                        oErrCode  <= ERR_TIMEOUT;
                        oErrCnt   <= sat_inc(oErrCnt);
                        state     <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (iRxDv) begin
                        // Checksum is tested first so it wins over a bad opcode.
                        if (iRxByte != (opc_q ^ arg_q)) begin
                            oErrPulse <= 1'b1;
                            oErrCode  <= ERR_CHKSUM;
                            oErrCnt   <= sat_inc(oErrCnt);
                            state     <= ST_IDLE;
                        end else if (opc_q[7:OPC_W] != '0) begin
                            oErrPulse <= 1'b1;
                            oErrCode  <= ERR_OPCODE;
                            oErrCnt   <= sat_inc(oErrCnt);
                            state     <= ST_IDLE;
                        end else begin
                            oCmd      <= opc_q[OPC_W-1:0];
                            oCmdArg   <= arg_q;
                            oCmdValid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end else if (tmo_expire) begin
                        oErrPulse <= 1'b1;
                        oErrCode  <= ERR_TIMEOUT;
                        oErrCnt   <= sat_inc(oErrCnt);
                        state     <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (iRxDv) begin
                        oErrPulse <= 1'b1;
                        oErrCode  <= ERR_OVERRUN;
                        oErrCnt   <= sat_inc(oErrCnt);
                    end
                    if (iCmdReady) begin
                        oCmdValid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
